name_word_deserializer: RTL

- Receive end of the name-component word stream feeding the FIB lookup pipeline.
- Takes one WORD_SIZE name component per accepted beat (valid/ready, last marks the final component) and reassembles whole names into a ping-pong buffer.
- Presents each complete name in parallel, with its component count, to the lookup stages via a valid/ready handshake.
- Decouples the serial name source from the pipeline so back-pressure never loses words.

---
 rtl/name_word_deserializer.sv | 116 +++++++++++
 1 files changed

// File: rtl/name_word_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : name_word_deserializer
// Purpose  : Reassembles serial name-component words into whole names held in
//            a two-entry ping-pong buffer and presents them in parallel.
// Revision : 1.0 - initial release
// ============================================================================
module name_word_deserializer #(
    parameter int WORD_SIZE       = 32,
    parameter int MAX_NAME_LENGTH = 8,
    parameter int LEN_SIZE        = 4,
    parameter int COUNT_SIZE      = 8
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic [WORD_SIZE-1:0]                 in_word,
    input  logic                                 in_valid,
    input  logic                                 in_last,
    output logic                                 in_ready,
    output logic [WORD_SIZE*MAX_NAME_LENGTH-1:0] out_name,
    output logic [LEN_SIZE-1:0]                  out_length,
    output logic                                 out_truncated,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [COUNT_SIZE-1:0]                trunc_count
);

    localparam logic [LEN_SIZE-1:0] C_MAX_LEN = LEN_SIZE'(MAX_NAME_LENGTH);

    logic [WORD_SIZE-1:0]  r_buf [0:1][0:MAX_NAME_LENGTH-1];
    logic [LEN_SIZE-1:0]   r_len   [0:1];
    logic                  r_tflag [0:1];
    logic                  r_full  [0:1];
    logic                  r_wsel;
    logic                  r_rsel;
    logic [LEN_SIZE-1:0]   r_widx;
    logic                  r_trunc;
    logic [COUNT_SIZE-1:0] r_trunc_count;

    logic                  w_accept;
    logic                  w_pop;
    logic                  w_at_max;
    logic                  w_commit_trunc;
    logic [LEN_SIZE-1:0]   w_commit_len;

    assign in_ready       = !r_full[r_wsel];
    assign out_valid      = r_full[r_rsel];
    assign out_length     = r_len[r_rsel];
    assign out_truncated  = r_tflag[r_rsel];
    assign trunc_count    = r_trunc_count;

    assign w_accept       = in_valid && in_ready;
    assign w_pop          = out_valid && out_ready;
    assign w_at_max       = (r_widx == C_MAX_LEN);
    assign w_commit_trunc = r_trunc || w_at_max;
    assign w_commit_len   = w_at_max ? C_MAX_LEN : r_widx + LEN_SIZE'(1);

    always_comb begin
        out_name = '0;
        for (int k = 0; k < MAX_NAME_LENGTH; k++) begin
            out_name[k*WORD_SIZE +: WORD_SIZE] = r_buf[r_rsel][k];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < MAX_NAME_LENGTH; k++) begin
                    r_buf[b][k] <= '0;
                end
                r_len[b]   <= '0;
                r_tflag[b] <= 1'b0;
                r_full[b]  <= 1'b0;
            end
            r_wsel        <= 1'b0;
            r_rsel        <= 1'b0;
            r_widx        <= '0;
            r_trunc       <= 1'b0;
            r_trunc_count <= '0;
        end else begin
            // Pop and commit always address different buffers, so both may fire.
            if (w_pop) begin
                r_full[r_rsel] <= 1'b0;
                r_rsel         <= ~r_rsel;
            end
            if (w_accept) begin
                // The first word also clears the rest of the buffer so short
                // names never expose components from an older name.
                for (int k = 0; k < MAX_NAME_LENGTH; k++) begin
                    if (LEN_SIZE'(k) == r_widx) begin
                        r_buf[r_wsel][k] <= in_word;
                    end else if (r_widx == '0) begin
                        r_buf[r_wsel][k] <= '0;
                    end
                end
                if (in_last) begin
                    r_len[r_wsel]   <= w_commit_len;
                    r_tflag[r_wsel] <= w_commit_trunc;
                    r_full[r_wsel]  <= 1'b1;
                    r_wsel          <= ~r_wsel;
                    r_widx          <= '0;
                    r_trunc         <= 1'b0;
                    if (w_commit_trunc && (r_trunc_count != '1)) begin
                        r_trunc_count <= r_trunc_count + COUNT_SIZE'(1);
                    end
                end else if (w_at_max) begin
                    r_trunc <= 1'b1;
                end else begin
                    r_widx <= r_widx + LEN_SIZE'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire
